// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Purpose  : instruction-fetch stage; owns the PC, fetches over req/ack and
//            computes the next PC after decode retires the current Ins.
// Revision : 1.0
// ============================================================================
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [5:0]  OP_J     = 6'd2,
  parameter logic [5:0]  OP_JAL   = 6'd3,
  parameter logic [5:0]  OP_BEQ   = 6'd4,
  parameter logic [5:0]  OP_BNE   = 6'd5,
  parameter logic [5:0]  FN_JR    = 6'd8
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        IReq,
  output logic [31:0] IAddr,
  input  logic        IAck,
  input  logic [31:0] IData,
  input  logic        Hold,
  input  logic        Zero,
  input  logic [31:0] Rdata1,
  output logic [31:0] Ins,
  output logic        InsValid,
  output logic [31:0] PC,
  output logic [31:0] PC4,
  output logic        Misalign
);

  localparam logic [5:0] c_OP_RTYPE = 6'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ins;
  logic        r_ins_valid;
  logic        r_ireq;
  logic        r_misalign;

  logic [5:0]  w_opc;
  logic [5:0]  w_funct;
  logic [31:0] w_pc4;
  logic [31:0] w_br_off;
  logic [31:0] w_next_pc;
  logic        w_jr_mis;

  assign w_opc    = r_ins[31:26];
  assign w_funct  = r_ins[5:0];
  assign w_pc4    = r_pc + 32'd4;
  assign w_br_off = {{14{r_ins[15]}}, r_ins[15:0], 2'b00};

  // Next-PC selection; only meaningful in the retire cycle, when Zero/Rdata1 are valid.
  always_comb begin
    w_next_pc = w_pc4;
    w_jr_mis  = 1'b0;
    if (w_opc == OP_J || w_opc == OP_JAL) begin
      w_next_pc = {w_pc4[31:28], r_ins[25:0], 2'b00};
    end else if ((w_opc == OP_BEQ && Zero) || (w_opc == OP_BNE && !Zero)) begin
      w_next_pc = w_pc4 + w_br_off;
    end else if (w_opc == c_OP_RTYPE && w_funct == FN_JR) begin
      w_next_pc = {Rdata1[31:2], 2'b00};
      w_jr_mis  = |Rdata1[1:0];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_pc        <= {RESET_PC[31:2], 2'b00};
      r_ins       <= 32'd0;
      r_ins_valid <= 1'b0;
      r_ireq      <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ireq  <= 1'b1;
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (IAck) begin
            r_ins       <= IData;
            r_ins_valid <= 1'b1;
            r_ireq      <= 1'b0;
            r_state     <= S_VALID;
          end
        end
        S_VALID: begin
          if (!Hold) begin
            r_pc        <= w_next_pc;
            r_ins_valid <= 1'b0;
            r_ireq      <= 1'b1;
            r_misalign  <= r_misalign | w_jr_mis;
            r_state     <= S_REQ;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_ireq      <= 1'b0;
          r_ins_valid <= 1'b0;
        end
      endcase
    end
  end

  assign IReq     = r_ireq;
  assign IAddr    = r_pc;
  assign Ins      = r_ins;
  assign InsValid = r_ins_valid;
  assign PC       = r_pc;
  assign PC4      = w_pc4;
  assign Misalign = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch
// Purpose  : self-checking bench for if_fetch with a transaction-level PC model.
// Revision : 1.0
// ============================================================================
module tb_if_fetch;

  localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] c_ADDI     = 32'h2008_0005;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IReq;
  logic [31:0] IAddr;
  logic        IAck = 1'b0;
  logic [31:0] IData = 32'd0;
  logic        Hold = 1'b0;
  logic        Zero = 1'b0;
  logic [31:0] Rdata1 = 32'd0;
  logic [31:0] Ins;
  logic        InsValid;
  logic [31:0] PC;
  logic [31:0] PC4;
  logic        Misalign;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] m_pc  = c_RESET_PC;
  logic        m_mis = 1'b0;

  if_fetch dut (
    .CLK(CLK), .RST(RST), .IReq(IReq), .IAddr(IAddr), .IAck(IAck), .IData(IData),
    .Hold(Hold), .Zero(Zero), .Rdata1(Rdata1), .Ins(Ins), .InsValid(InsValid),
    .PC(PC), .PC4(PC4), .Misalign(Misalign)
  );

  always #5 CLK = ~CLK;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic is_jr(input logic [31:0] ins);
    return (ins[31:26] == 6'd0) && (ins[5:0] == 6'd8);
  endfunction

  // Architectural next-PC rule, in plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] ins,
                                           input logic zero, input logic [31:0] rdata1);
    logic [31:0] pc4;
    int          off;
    pc4 = pc + 32'd4;
    off = int'($signed(ins[15:0]));
    case (ins[31:26])
      6'd2, 6'd3: return (pc4 & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
      6'd4:       return zero ? pc4 + 32'(off * 4) : pc4;
      6'd5:       return !zero ? pc4 + 32'(off * 4) : pc4;
      default:    return is_jr(ins) ? (rdata1 / 4) * 4 : pc4;
    endcase
  endfunction

  task automatic do_reset();
    RST  = 1'b1;
    IAck = 1'b0;
    Hold = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST   = 1'b0;
    m_pc  = c_RESET_PC;
    m_mis = 1'b0;
  endtask

  // One complete fetch/retire transaction against the model.
  task automatic fetch(input string tag, input logic [31:0] ins, input int delay,
                       input int hold, input logic zero, input logic [31:0] rdata1);
    int          n;
    logic [31:0] exp_next;
    n = 0;
    while (IReq !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    vectors++;
    if (IReq !== 1'b1) begin
      $display("FAIL %s req_timeout IReq=%b required 1", tag, IReq);
      miscompares++;
      return;
    end
    vectors++;
    if (IAddr !== m_pc || InsValid !== 1'b0) begin
      $display("FAIL %s iaddr got=%h required=%h InsValid=%b", tag, IAddr, m_pc, InsValid);
      miscompares++;
    end
    for (int d = 0; d < delay; d++) begin
      IAck  = 1'b0;
      IData = $urandom;
      @(negedge CLK);
      vectors++;
      if (IReq !== 1'b1 || InsValid !== 1'b0 || IAddr !== m_pc) begin
        $display("FAIL %s req_wait IReq=%b InsValid=%b IAddr=%h required 1/0/%h",
                 tag, IReq, InsValid, IAddr, m_pc);
        miscompares++;
      end
    end
    IAck  = 1'b1;
    IData = ins;
    @(negedge CLK);
    IAck  = 1'b0;
    IData = $urandom;
    vectors++;
    if (InsValid !== 1'b1 || IReq !== 1'b0 || Ins !== ins || PC !== m_pc || PC4 !== m_pc + 32'd4) begin
      $display("FAIL %s valid InsValid=%b IReq=%b Ins=%h PC=%h PC4=%h required 1/0/%h/%h/%h",
               tag, InsValid, IReq, Ins, PC, PC4, ins, m_pc, m_pc + 32'd4);
      miscompares++;
    end
    Hold = 1'b1;
    for (int h = 0; h < hold; h++) begin
      Zero   = rbit();
      Rdata1 = $urandom;
      IAck   = rbit();
      @(negedge CLK);
      vectors++;
      if (InsValid !== 1'b1 || IReq !== 1'b0 || Ins !== ins || PC !== m_pc || PC4 !== m_pc + 32'd4) begin
        $display("FAIL %s hold InsValid=%b IReq=%b Ins=%h PC=%h PC4=%h required 1/0/%h/%h/%h",
                 tag, InsValid, IReq, Ins, PC, PC4, ins, m_pc, m_pc + 32'd4);
        miscompares++;
      end
    end
    IAck     = 1'b0;
    Hold     = 1'b0;
    Zero     = zero;
    Rdata1   = rdata1;
    exp_next = ref_next(m_pc, ins, zero, rdata1);
    if (is_jr(ins) && rdata1[1:0] != 2'b00) m_mis = 1'b1;
    @(negedge CLK);
    Hold   = rbit();
    Zero   = rbit();
    Rdata1 = $urandom;
    vectors++;
    if (InsValid !== 1'b0 || IReq !== 1'b1 || PC !== exp_next || IAddr !== exp_next || Misalign !== m_mis) begin
      $display("FAIL %s retire InsValid=%b IReq=%b PC=%h IAddr=%h Misalign=%b required 0/1/%h/%h/%b",
               tag, InsValid, IReq, PC, IAddr, Misalign, exp_next, exp_next, m_mis);
      miscompares++;
    end
    m_pc = exp_next;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    vectors++;
    if (IReq !== 1'b0 || InsValid !== 1'b0 || Ins !== 32'd0 || PC !== c_RESET_PC || Misalign !== 1'b0) begin
      $display("FAIL reset_values IReq=%b InsValid=%b Ins=%h PC=%h Misalign=%b required 0/0/0/%h/0",
               IReq, InsValid, Ins, PC, Misalign, c_RESET_PC);
      miscompares++;
    end
    RST   = 1'b0;
    m_pc  = c_RESET_PC;
    m_mis = 1'b0;
    @(negedge CLK);
    vectors++;
    if (IReq !== 1'b1 || InsValid !== 1'b0 || IAddr !== c_RESET_PC) begin
      $display("FAIL reset_release IReq=%b InsValid=%b IAddr=%h required 1/0/%h",
               IReq, InsValid, IAddr, c_RESET_PC);
      miscompares++;
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) fetch("seq", c_ADDI, 0, 0, 1'b0, 32'd0);
  endtask

  task automatic test_delay_hold();
    fetch("delay_hold", c_ADDI, 3, 2, 1'b1, 32'hFFFF_FFFF);
  endtask

  task automatic test_jump();
    do_reset();
    for (int i = 0; i < 4; i++) fetch("to_0x10", c_ADDI, 0, 0, 1'b0, 32'd0);
    fetch("j", {6'd2, 26'h000_0040}, 1, 0, 1'b0, 32'd0);
    do_reset();
    for (int i = 0; i < 4; i++) fetch("to_0x10", c_ADDI, 0, 0, 1'b0, 32'd0);
    fetch("jal", {6'd3, 26'h000_0040}, 0, 1, 1'b0, 32'd0);
  endtask

  task automatic test_branch();
    logic [31:0] j20;
    j20 = {6'd2, 26'h000_0008};
    fetch("j_0x20", j20, 0, 0, 1'b0, 32'd0);
    fetch("beq_taken", {6'd4, 5'd1, 5'd2, 16'hFFFE}, 0, 0, 1'b1, 32'd0);
    fetch("j_0x20", j20, 0, 0, 1'b0, 32'd0);
    fetch("beq_not_taken", {6'd4, 5'd1, 5'd2, 16'hFFFE}, 0, 0, 1'b0, 32'd0);
    fetch("j_0x20", j20, 0, 0, 1'b0, 32'd0);
    fetch("bne_taken", {6'd5, 5'd1, 5'd2, 16'hFFFE}, 0, 0, 1'b0, 32'd0);
  endtask

  task automatic test_jr();
    fetch("jr_mis", {6'd0, 5'd3, 15'd0, 6'd8}, 0, 0, 1'b0, 32'h0000_0403);
    fetch("after_jr", c_ADDI, 0, 0, 1'b0, 32'd0);
    do_reset();
    @(negedge CLK);
    vectors++;
    if (Misalign !== 1'b0 || PC !== c_RESET_PC) begin
      $display("FAIL jr_reset Misalign=%b PC=%h required 0/%h", Misalign, PC, c_RESET_PC);
      miscompares++;
    end
  endtask

  task automatic test_wrap();
    fetch("jr_top", {6'd0, 5'd3, 15'd0, 6'd8}, 0, 0, 1'b0, 32'hFFFF_FFFC);
    fetch("wrap", c_ADDI, 1, 1, 1'b0, 32'd0);
    fetch("after_wrap", c_ADDI, 0, 0, 1'b0, 32'd0);
  endtask

  task automatic test_reset_mid_req();
    int n;
    n = 0;
    while (IReq !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    IAck = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST  = 1'b1;
    IAck = 1'b1;
    @(negedge CLK);
    vectors++;
    if (IReq !== 1'b0 || InsValid !== 1'b0 || PC !== c_RESET_PC || Misalign !== 1'b0) begin
      $display("FAIL rst_mid_req IReq=%b InsValid=%b PC=%h Misalign=%b required 0/0/%h/0",
               IReq, InsValid, PC, Misalign, c_RESET_PC);
      miscompares++;
    end
    RST   = 1'b0;
    m_pc  = c_RESET_PC;
    m_mis = 1'b0;
    @(negedge CLK);
    IAck = 1'b0;
    vectors++;
    if (IReq !== 1'b1 || InsValid !== 1'b0) begin
      $display("FAIL stray_ack IReq=%b InsValid=%b required 1/0", IReq, InsValid);
      miscompares++;
    end
    fetch("post_rst", c_ADDI, 0, 0, 1'b0, 32'd0);
  endtask

  task automatic test_random();
    logic [31:0] ins;
    logic [31:0] rd;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 5))
        0:       ins = {6'h08, 26'($urandom)};
        1:       ins = {6'd2, 26'($urandom)};
        2:       ins = {6'd3, 26'($urandom)};
        3:       ins = {6'd4, 10'($urandom), 16'($urandom)};
        4:       ins = {6'd5, 10'($urandom), 16'($urandom)};
        default: ins = {6'd0, 5'($urandom), 15'd0, 6'd8};
      endcase
      rd = $urandom;
      if (rbit()) rd[1:0] = 2'b00;
      fetch("random", ins, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rbit(), rd);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_delay_hold();
    test_jump();
    test_branch();
    test_jr();
    test_wrap();
    test_reset_mid_req();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage directly upstream of the decode/register-file stage.
- Owns the PC and fetches one instruction at a time from instruction memory over a req/ack handshake.
- Presents the instruction (Ins) and PC+4 (link value for JAL) to decode.
- After decode/execute retires the instruction, computes the next PC: sequential, J/JAL, BEQ/BNE, JR.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- OP_J, 6'd2, opcode of J.
- OP_JAL, 6'd3, opcode of JAL.
- OP_BEQ, 6'd4, opcode of BEQ.
- OP_BNE, 6'd5, opcode of BNE.
- FN_JR, 6'd8, R-form funct of JR (opcode 6'd0).

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  synchronous, active-high reset.
- IReq  out  1  instruction-memory request.
- IAddr  out  32  fetch address; equals PC, bits [1:0] always 0.
- IAck  in  1  memory has IData valid this cycle.
- IData  in  32  instruction word from memory.
- Hold  in  1  downstream not ready to retire the current Ins.
- Zero  in  1  ALU zero flag for the current Ins (rs==rt).
- Rdata1  in  32  rs register value, used as the JR target.
- Ins  out  32  current instruction to decode.
- InsValid  out  1  Ins holds a fetched instruction.
- PC  out  32  address of Ins.
- PC4  out  32  PC+4, the JAL link value.
- Misalign  out  1  sticky flag: a JR target had bits [1:0] != 0.

Behaviour:
- Single clock. Reset is synchronous and active-high, sampled on posedge CLK (CLK/RST naming as elsewhere in the codebase).
- Reset values:
  - state=IDLE, PC=RESET_PC, Ins=32'd0 (decode treats 0 as NOP).
  - InsValid=0, IReq=0, Misalign=0.
- FSM states: IDLE, REQ, VALID. All outputs are registered.
- IDLE: on the first cycle with RST=0, go to REQ; IReq=1 from the next cycle.
- REQ:
  - IReq=1, IAddr=PC.
  - On a cycle with IAck=1: Ins<=IData, InsValid<=1, IReq<=0, go to VALID.
  - Ack in the same cycle as first req assertion is legal: one-cycle memory gives IReq high for exactly 1 cycle.
  - Otherwise wait indefinitely.
- VALID:
  - Ins, PC and PC4 are stable while Hold=1.
  - The cycle with Hold=0 is the retire cycle: PC<=next_pc, InsValid<=0, IReq<=1, go to REQ.
  - Zero and Rdata1 are sampled in the retire cycle only.
- next_pc (opc=Ins[31:26], funct=Ins[5:0]):
  - J/JAL: {PC4[31:28], Ins[25:0], 2'b00}.
  - BEQ with Zero=1, or BNE with Zero=0: PC4 + ({{14{Ins[15]}}, Ins[15:0], 2'b00}), mod 2^32.
  - JR (opc=0, funct=FN_JR): {Rdata1[31:2], 2'b00}. If Rdata1[1:0] != 0, set Misalign (sticky until RST).
  - Else (including Ins==0): PC4.
- PC4 = PC+4 mod 2^32, so 32'hFFFF_FFFC wraps to 0. Updated combinationally from the PC register or registered alongside it; either way it is valid whenever InsValid=1.
- IAck outside REQ is ignored. IData is don't-care when IAck=0.
- Hold is ignored outside VALID.
- RST in any state (including mid-REQ with an outstanding request) returns to reset values next cycle. A late IAck after reset is ignored unless the FSM is in REQ again; memory must tolerate request abandonment.
- Throughput: at best one instruction per 2 cycles (REQ+ack, VALID retire).

Test Plan:
- Reset, then memory acks in the same cycle as each req, IData = 32'h2008_0005 (addi), Hold=0:
  - IAddr sequence 0,4,8.
  - InsValid high every other cycle.
  - Ins=32'h2008_0005, PC4=4 on the first VALID.
- Memory delays IAck by 3 cycles; Hold=1 for 2 cycles in VALID:
  - IReq high 4 cycles.
  - Ins/PC unchanged during Hold.
  - PC advances only on the Hold=0 cycle.
- At PC=32'h0000_0010, Ins=J with target field 26'h0000040:
  - next IAddr=32'h0000_0100.
  - JAL same target: PC4=32'h0000_0014 while valid.
- BEQ at PC=0x20 with offset 16'hFFFE:
  - Zero=1 -> next IAddr=0x1C.
  - Zero=0 -> next IAddr=0x24.
  - BNE with Zero=0 -> 0x1C.
- JR with Rdata1=32'h0000_0403:
  - next IAddr=32'h0000_0400; Misalign=1 and stays 1.
  - RST clears it; PC returns to RESET_PC.
- PC=32'hFFFF_FFFC, non-branch Ins -> next IAddr=0. RST asserted while in REQ awaiting ack -> IReq=0 and InsValid=0 next cycle; a stray IAck is ignored.
